// File: rtl/multi_seven_seg_scan.sv
// Time-multiplexed common-anode seven-segment scanner for NUM_DIGITS hex digits.
// Adds decimal points, leading-zero blanking, PWM dimming and frame-coherent input snapshots.
module multi_seven_seg_scan #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 20000,
  parameter int BRIGHT_W       = 4,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] vals,
  input  logic [NUM_DIGITS-1:0]   dps,
  input  logic                    blank_lz,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int RCNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [RCNT_W-1:0]     RCNT_LAST = RCNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{AN_ACTIVE_LOW}};
  localparam logic [6:0]            SEG_OFF   = {7{SEG_ACTIVE_LOW}};
  localparam logic                  DP_OFF    = SEG_ACTIVE_LOW;

  logic [RCNT_W-1:0]       r_rcnt;
  logic [IDX_W-1:0]        r_idx;
  logic [BRIGHT_W-1:0]     r_pcnt;
  logic                    r_init;
  logic [4*NUM_DIGITS-1:0] r_vals_s;
  logic [NUM_DIGITS-1:0]   r_dps_s;
  logic                    r_blank_s;
  logic                    r_fb_d;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic                    r_frame_tick;

  logic                    w_slot_end;
  logic                    w_frame_bound;
  logic                    w_load;
  logic [4*NUM_DIGITS-1:0] w_vals_eff;
  logic [NUM_DIGITS-1:0]   w_dps_eff;
  logic                    w_blank_eff;
  logic [3:0]              w_nib;
  logic                    w_dp_req;
  logic                    w_zero_run;
  logic [NUM_DIGITS-1:0]   w_blank;
  logic                    w_digit_on;
  logic [NUM_DIGITS-1:0]   w_an_act;
  logic [6:0]              w_font_low;

  assign w_slot_end    = (r_rcnt == RCNT_LAST);
  assign w_frame_bound = w_slot_end && (r_idx == IDX_LAST);
  assign w_load        = r_init | w_frame_bound;

  // The first edge after reset both loads the shadows and drives digit 0, so bypass them then.
  assign w_vals_eff  = r_init ? vals     : r_vals_s;
  assign w_dps_eff   = r_init ? dps      : r_dps_s;
  assign w_blank_eff = r_init ? blank_lz : r_blank_s;

  assign w_digit_on = (r_pcnt <= brightness);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rcnt <= '0;
      r_idx  <= '0;
      r_pcnt <= '0;
      r_init <= 1'b1;
      r_fb_d <= 1'b0;
    end else begin
      r_init <= 1'b0;
      r_pcnt <= r_pcnt + BRIGHT_W'(1);
      r_fb_d <= w_frame_bound;
      if (w_slot_end) begin
        r_rcnt <= '0;
        r_idx  <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
      end else begin
        r_rcnt <= r_rcnt + RCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vals_s  <= '0;
      r_dps_s   <= '0;
      r_blank_s <= 1'b0;
    end else if (w_load) begin
      r_vals_s  <= vals;
      r_dps_s   <= dps;
      r_blank_s <= blank_lz;
    end
  end

  always_comb begin
    w_nib    = 4'h0;
    w_dp_req = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib    = w_vals_eff[4*i +: 4];
        w_dp_req = w_dps_eff[i];
      end
    end
  end

  // Walk from the most significant digit down; a digit is blank while the zero run is unbroken.
  always_comb begin
    w_zero_run = 1'b1;
    w_blank    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zero_run = w_zero_run & (w_vals_eff[4*i +: 4] == 4'h0);
      if (i > 0) begin
        w_blank[i] = w_blank_eff & w_zero_run;
      end
    end
  end

  always_comb begin
    w_an_act = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_an_act[i] = (r_idx == IDX_W'(i)) && w_digit_on && !w_blank[i];
    end
  end

  always_comb begin
    w_font_low = 7'b1111111;
    case (w_nib)
      4'h0: w_font_low = 7'b0000001;
      4'h1: w_font_low = 7'b1001111;
      4'h2: w_font_low = 7'b0010010;
      4'h3: w_font_low = 7'b0000110;
      4'h4: w_font_low = 7'b1001100;
      4'h5: w_font_low = 7'b0100100;
      4'h6: w_font_low = 7'b0100000;
      4'h7: w_font_low = 7'b0001111;
      4'h8: w_font_low = 7'b0000000;
      4'h9: w_font_low = 7'b0000100;
      4'hA: w_font_low = 7'b0001000;
      4'hB: w_font_low = 7'b1100000;
      4'hC: w_font_low = 7'b0110001;
      4'hD: w_font_low = 7'b1000010;
      4'hE: w_font_low = 7'b0110000;
      4'hF: w_font_low = 7'b0111000;
      default: w_font_low = 7'b1111111;
    endcase
  end

  // All pins update together from one register stage, so anodes never overlap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an         <= AN_OFF;
      r_seg        <= SEG_OFF;
      r_dp         <= DP_OFF;
      r_frame_tick <= 1'b0;
    end else begin
      r_an         <= AN_ACTIVE_LOW  ? ~w_an_act   : w_an_act;
      r_seg        <= SEG_ACTIVE_LOW ? w_font_low  : ~w_font_low;
      r_dp         <= SEG_ACTIVE_LOW ? ~w_dp_req   : w_dp_req;
      r_frame_tick <= r_fb_d;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_multi_seven_seg_scan.sv
// Scoreboard bench for multi_seven_seg_scan: a cycle-count reference model queues the
// expected pin values for every clock, and a separate monitor pops and compares them.
module tb_multi_seven_seg_scan;

  localparam int ND    = 4;
  localparam int RD    = 4;
  localparam int BW    = 2;
  localparam int FRAME = ND * RD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] vals = 16'h0;
  logic [3:0]  dps = 4'h0;
  logic        blank_lz = 1'b0;
  logic [1:0]  brightness = 2'd3;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
  } exp_t;

  exp_t       q[$];
  int         total = 0;
  int         bad = 0;
  int         t = 0;
  logic [3:0] sh [ND];
  logic [3:0] sh_dp;
  logic       sh_blank;
  logic [6:0] font [16];

  multi_seven_seg_scan #(
    .NUM_DIGITS(ND), .REFRESH_DIV(RD), .BRIGHT_W(BW),
    .AN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vals(vals), .dps(dps), .blank_lz(blank_lz),
    .brightness(brightness), .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic load_shadow();
    for (int i = 0; i < ND; i++) sh[i] = vals[4*i +: 4];
    sh_dp    = dps;
    sh_blank = blank_lz;
  endtask

  // n = clock edges since reset release before this edge
  function automatic exp_t compute(input int n);
    exp_t e;
    int   idx;
    int   pc;
    bit   blanked;
    idx = (n / RD) % ND;
    pc  = n % (1 << BW);
    blanked = 1'b0;
    if (idx > 0 && sh_blank) begin
      blanked = 1'b1;
      for (int j = idx; j < ND; j++) if (sh[j] != 4'h0) blanked = 1'b0;
    end
    e.an = 4'hF;
    if (pc <= int'(brightness) && !blanked) e.an[idx] = 1'b0;
    e.seg = font[sh[idx]];
    e.dp  = ~sh_dp[idx];
    e.ft  = (n >= 1) && (((n - 1) % FRAME) == FRAME - 1);
    return e;
  endfunction

  task automatic step();
    exp_t e;
    if (!rst_n) begin
      e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, ft: 1'b0};
      t = 0;
    end else begin
      if (t == 0) load_shadow();
      e = compute(t);
      if ((t % FRAME) == FRAME - 1) load_shadow();
      t++;
    end
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic async_reset(input int cyc);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_an", an, 4'hF);
    chk("async_seg", seg, 7'h7F);
    chk("async_dp", dp, 1'b1);
    chk("async_ft", frame_tick, 1'b0);
    run(cyc);
    rst_n = 1'b1;
  endtask

  function automatic int next_idx();
    return (t / RD) % ND;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("an", an, e.an);
        chk("seg", seg, e.seg);
        chk("dp", dp, e.dp);
        chk("frame_tick", frame_tick, e.ft);
      end
    end
  end

  initial begin : driver
    logic [15:0] masks [5];
    font[0]  = 7'b0000001; font[1]  = 7'b1001111; font[2]  = 7'b0010010; font[3]  = 7'b0000110;
    font[4]  = 7'b1001100; font[5]  = 7'b0100100; font[6]  = 7'b0100000; font[7]  = 7'b0001111;
    font[8]  = 7'b0000000; font[9]  = 7'b0000100; font[10] = 7'b0001000; font[11] = 7'b1100000;
    font[12] = 7'b0110001; font[13] = 7'b1000010; font[14] = 7'b0110000; font[15] = 7'b0111000;
    masks[0] = 16'hFFFF; masks[1] = 16'h0FFF; masks[2] = 16'h00FF;
    masks[3] = 16'h000F; masks[4] = 16'h0000;

    vals = 16'h1234; dps = 4'b0100; brightness = 2'd3; blank_lz = 1'b0;
    @(negedge clk);
    chk("reset_an", an, 4'hF);
    chk("reset_seg", seg, 7'h7F);
    run(2);
    rst_n = 1'b1;

    // Basic scan, then change inputs while digit 2 is showing
    run(40);
    while (next_idx() != 2) step();
    vals = 16'hABCD; dps = 4'b0011;
    run(36);

    // Leading-zero blanking
    vals = 16'h0050; blank_lz = 1'b1; dps = 4'h0;
    run(36);
    vals = 16'h0000;
    run(36);
    blank_lz = 1'b0;
    run(36);

    // PWM duty
    vals = 16'h8E2F;
    brightness = 2'd1; run(32);
    brightness = 2'd0; run(32);
    brightness = 2'd3; run(32);

    // Reset pulse while digit 3 is showing
    while (next_idx() != 3) step();
    vals = 16'h7C09; dps = 4'b1001;
    async_reset(1);
    run(24);

    // Randomized inputs, live brightness
    for (int i = 0; i < 400; i++) begin
      brightness = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) begin
        vals     = 16'($urandom) & masks[$urandom_range(0, 4)];
        dps      = 4'($urandom);
        blank_lz = 1'($urandom);
      end
      if (i == 213) async_reset(1 + $urandom_range(0, 2));
      step();
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
